// File: rtl/logic_op_arbiter_if.sv
// Request and result channels between four requesters and the shared
// bitwise logic unit.
interface logic_op_arbiter_if #(
  parameter int WIDTH = 8
);
  logic [3:0]         req_valid;
  logic [3:0]         req_ready;
  logic [11:0]        req_op;
  logic [4*WIDTH-1:0] req_a;
  logic [4*WIDTH-1:0] req_b;
  logic               res_valid;
  logic               res_ready;
  logic [WIDTH-1:0]   res_data;
  logic [1:0]         res_id;
  logic               res_err;

  modport master (
    output req_valid,
    output req_op,
    output req_a,
    output req_b,
    output res_ready,
    input  req_ready,
    input  res_valid,
    input  res_data,
    input  res_id,
    input  res_err
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  req_a,
    input  req_b,
    input  res_ready,
    output req_ready,
    output res_valid,
    output res_data,
    output res_id,
    output res_err
  );
endinterface

// File: rtl/logic_op_arbiter.sv
// Round-robin shared bitwise logic unit for four requesters with a
// registered valid/ready result channel and saturating statistics.
module logic_op_arbiter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  logic_op_arbiter_if.slave bus,
  output logic [CNT_W-1:0] op_count,
  output logic [CNT_W-1:0] err_count
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] EXEC = 2'd1;
  localparam logic [1:0] HOLD = 2'd2;

  localparam logic [2:0] OP_AND  = 3'd0;
  localparam logic [2:0] OP_OR   = 3'd1;
  localparam logic [2:0] OP_NOT  = 3'd2;
  localparam logic [2:0] OP_NAND = 3'd3;
  localparam logic [2:0] OP_NOR  = 3'd4;
  localparam logic [2:0] OP_XOR  = 3'd5;
  localparam logic [2:0] OP_XNOR = 3'd6;

  localparam logic [CNT_W-1:0] CNT_ONE = 1;
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [1:0]       state;
  logic [1:0]       ptr;
  logic [1:0]       gnt;
  logic [1:0]       cand;
  logic             found;
  logic             take;
  logic [2:0]       sel_op;
  logic [WIDTH-1:0] sel_a;
  logic [WIDTH-1:0] sel_b;
  logic [2:0]       op_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [1:0]       id_q;
  logic [WIDTH-1:0] alu;
  logic             alu_err;

  // Scan from ptr+3 down to ptr so the nearest valid requester wins.
  always_comb begin
    found = 1'b0;
    gnt   = ptr;
    cand  = ptr;
    for (int k = 3; k >= 0; k--) begin
      cand = ptr + 2'(k);
      if (bus.req_valid[cand]) begin
        found = 1'b1;
        gnt   = cand;
      end
    end
  end

  assign take = (state == IDLE) && found && !rst;

  always_comb begin
    bus.req_ready = '0;
    if (take) begin
      bus.req_ready[gnt] = 1'b1;
    end
  end

  always_comb begin
    sel_op = bus.req_op[3*int'(gnt) +: 3];
    sel_a  = bus.req_a[WIDTH*int'(gnt) +: WIDTH];
    sel_b  = bus.req_b[WIDTH*int'(gnt) +: WIDTH];
  end

  always_comb begin
    alu     = '0;
    alu_err = 1'b0;
    unique case (op_q)
      OP_AND:  alu = a_q & b_q;
      OP_OR:   alu = a_q | b_q;
      OP_NOT:  alu = ~a_q;
      OP_NAND: alu = ~(a_q & b_q);
      OP_NOR:  alu = ~(a_q | b_q);
      OP_XOR:  alu = a_q ^ b_q;
      OP_XNOR: alu = ~(a_q ^ b_q);
      default: alu_err = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state         <= IDLE;
      ptr           <= 2'd0;
      op_q          <= 3'd0;
      a_q           <= '0;
      b_q           <= '0;
      id_q          <= 2'd0;
      bus.res_valid <= 1'b0;
      bus.res_data  <= '0;
      bus.res_id    <= 2'd0;
      bus.res_err   <= 1'b0;
      op_count      <= '0;
      err_count     <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (take) begin
            op_q  <= sel_op;
            a_q   <= sel_a;
            b_q   <= sel_b;
            id_q  <= gnt;
            ptr   <= gnt + 2'd1;
            state <= EXEC;
          end
        end
        EXEC: begin
          bus.res_data  <= alu;
          bus.res_err   <= alu_err;
          bus.res_id    <= id_q;
          bus.res_valid <= 1'b1;
          state         <= HOLD;
        end
        HOLD: begin
          if (bus.res_ready) begin
            bus.res_valid <= 1'b0;
            if (op_count != CNT_MAX) begin
              op_count <= op_count + CNT_ONE;
            end
            if (bus.res_err && err_count != CNT_MAX) begin
              err_count <= err_count + CNT_ONE;
            end
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_logic_op_arbiter.sv
// Scoreboard bench for logic_op_arbiter: grant order, latency,
// backpressure, illegal opcodes, async reset and counter saturation.
module tb_logic_op_arbiter;
  localparam int WIDTH = 8;
  localparam int CNT_W = 4;

  typedef struct packed {
    logic [7:0] data;
    logic [1:0] id;
    logic       err;
  } exp_t;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [CNT_W-1:0] op_count;
  logic [CNT_W-1:0] err_count;
  int               checks = 0;
  int               passes = 0;
  int               cyc = 0;
  exp_t             sb[$];

  logic_op_arbiter_if #(.WIDTH(WIDTH)) bus();

  logic_op_arbiter #(
    .WIDTH(WIDTH),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus),
    .op_count(op_count),
    .err_count(err_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  function automatic exp_t model(logic [2:0] op, logic [7:0] a,
                                 logic [7:0] b, logic [1:0] id);
    exp_t r;
    r.id = id;
    r.err = 1'b0;
    case (op)
      3'd0: r.data = a & b;
      3'd1: r.data = a | b;
      3'd2: r.data = ~a;
      3'd3: r.data = ~(a & b);
      3'd4: r.data = ~(a | b);
      3'd5: r.data = a ^ b;
      3'd6: r.data = ~(a ^ b);
      default: begin r.data = 8'h00; r.err = 1'b1; end
    endcase
    return r;
  endfunction

  function automatic int oh_idx(logic [3:0] v);
    for (int i = 0; i < 4; i++) if (v[i]) return i;
    return -1;
  endfunction

  // Scoreboard: push on each handshake, pop and compare on each handoff.
  always @(negedge clk) begin : monitor
    int g;
    exp_t e;
    exp_t got;
    if (!rst) begin
      if (|bus.req_ready) begin
        g = oh_idx(bus.req_ready);
        sb.push_back(model(bus.req_op[3*g +: 3], bus.req_a[8*g +: 8],
                           bus.req_b[8*g +: 8], 2'(g)));
      end
      if (bus.res_valid && bus.res_ready) begin
        checks++;
        got = {bus.res_data, bus.res_id, bus.res_err};
        if (sb.size() == 0) begin
          $display("FAIL sb_empty: got result %h, none expected", got);
        end else begin
          e = sb.pop_front();
          if (got !== e)
            $display("FAIL sb_result: got data=%h id=%0d err=%b want data=%h id=%0d err=%b",
                     got.data, got.id, got.err, e.data, e.id, e.err);
          else passes++;
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic idle_inputs();
    bus.req_valid = '0;
    bus.req_op    = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.res_ready = 1'b1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    idle_inputs();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    sb.delete();
  endtask

  task automatic wait_grant(output int ok);
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (|bus.req_ready) begin ok = 1; return; end
    end
  endtask

  task automatic wait_res(output int ok);
    ok = 0;
    for (int n = 0; n < 20; n++) begin
      @(negedge clk);
      if (bus.res_valid) begin ok = 1; return; end
    end
  endtask

  task automatic test_reset();
    idle_inputs();
    #2 rst = 1'b1;
    bus.req_valid = 4'hF;
    #2;
    checks++; if (bus.req_ready !== 4'h0) $display("FAIL rst_ready: got %b want 0000", bus.req_ready); else passes++;
    checks++; if (bus.res_valid !== 1'b0) $display("FAIL rst_valid: got %b want 0", bus.res_valid); else passes++;
    checks++; if (bus.res_data !== 8'h00) $display("FAIL rst_data: got %h want 00", bus.res_data); else passes++;
    checks++; if (op_count !== 4'd0) $display("FAIL rst_opcnt: got %0d want 0", op_count); else passes++;
    checks++; if (err_count !== 4'd0) $display("FAIL rst_errcnt: got %0d want 0", err_count); else passes++;
    bus.req_valid = 4'h0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic test_ops();
    logic [7:0] tab [7] = '{8'h30, 8'hFC, 8'h0F, 8'hCF, 8'h03, 8'hCC, 8'h33};
    int ok;
    int t0;
    do_reset();
    for (int i = 0; i < 7; i++) begin
      @(posedge clk); #1;
      bus.req_valid = 4'b0001;
      bus.req_op[2:0] = 3'(i);
      bus.req_a[7:0] = 8'hF0;
      bus.req_b[7:0] = 8'h3C;
      wait_grant(ok);
      t0 = cyc;
      checks++; if (bus.req_ready !== 4'b0001) $display("FAIL ops_grant%0d: got %b want 0001", i, bus.req_ready); else passes++;
      @(posedge clk); #1 bus.req_valid = 4'b0000;
      wait_res(ok);
      checks++; if (cyc - t0 !== 2) $display("FAIL ops_latency%0d: got %0d want 2", i, cyc - t0); else passes++;
      checks++; if (bus.res_data !== tab[i]) $display("FAIL ops_data%0d: got %h want %h", i, bus.res_data, tab[i]); else passes++;
      checks++; if (bus.res_id !== 2'd0) $display("FAIL ops_id%0d: got %0d want 0", i, bus.res_id); else passes++;
    end
    @(negedge clk);
    checks++; if (op_count !== 4'd7) $display("FAIL ops_count: got %0d want 7", op_count); else passes++;
  endtask

  task automatic test_round_robin();
    int ord [6] = '{0, 1, 2, 3, 0, 1};
    int ok;
    int g;
    int last;
    do_reset();
    @(posedge clk); #1;
    bus.req_op = {3'd6, 3'd5, 3'd1, 3'd0};
    bus.req_a = {8'h11, 8'h22, 8'h33, 8'h44};
    bus.req_b = {8'h0F, 8'hF0, 8'h55, 8'hAA};
    bus.req_valid = 4'hF;
    last = 0;
    for (int k = 0; k < 6; k++) begin
      wait_grant(ok);
      checks++; if (ok !== 1) $display("FAIL rr_timeout%0d: got no grant want grant", k); else passes++;
      g = oh_idx(bus.req_ready);
      checks++; if (g !== ord[k]) $display("FAIL rr_order%0d: got %0d want %0d", k, g, ord[k]); else passes++;
      if (k > 0) begin
        checks++; if (cyc - last !== 3) $display("FAIL rr_spacing%0d: got %0d want 3", k, cyc - last); else passes++;
      end
      last = cyc;
    end
    @(posedge clk); #1 bus.req_valid = 4'h0;
    repeat (6) @(negedge clk);
    checks++; if (sb.size() !== 0) $display("FAIL rr_drain: got %0d pending want 0", sb.size()); else passes++;
  endtask

  task automatic test_backpressure();
    int ok;
    int r;
    do_reset();
    @(posedge clk); #1;
    bus.res_ready = 1'b0;
    bus.req_op[8:6] = 3'd5;
    bus.req_a[23:16] = 8'h12;
    bus.req_b[23:16] = 8'h34;
    bus.req_valid = 4'b0100;
    wait_grant(ok);
    checks++; if (bus.req_ready !== 4'b0100) $display("FAIL bp_grant: got %b want 0100", bus.req_ready); else passes++;
    @(posedge clk); #1;
    bus.req_valid = 4'b0001;
    bus.req_a[7:0] = 8'h5A;
    bus.req_b[7:0] = 8'hA5;
    wait_res(ok);
    for (int k = 0; k < 5; k++) begin
      checks++; if (bus.res_valid !== 1'b1) $display("FAIL bp_valid%0d: got %b want 1", k, bus.res_valid); else passes++;
      checks++; if (bus.res_data !== 8'h26) $display("FAIL bp_data%0d: got %h want 26", k, bus.res_data); else passes++;
      checks++; if (bus.res_id !== 2'd2) $display("FAIL bp_id%0d: got %0d want 2", k, bus.res_id); else passes++;
      checks++; if (bus.req_ready !== 4'h0) $display("FAIL bp_ready%0d: got %b want 0000", k, bus.req_ready); else passes++;
      @(negedge clk);
    end
    @(posedge clk); #1 bus.res_ready = 1'b1;
    r = cyc;
    wait_grant(ok);
    checks++; if (cyc - r !== 1) $display("FAIL bp_regrant: got %0d cycles want 1", cyc - r); else passes++;
    checks++; if (bus.req_ready !== 4'b0001) $display("FAIL bp_next: got %b want 0001", bus.req_ready); else passes++;
    checks++; if (op_count !== 4'd1) $display("FAIL bp_count: got %0d want 1", op_count); else passes++;
    @(posedge clk); #1 bus.req_valid = 4'h0;
    repeat (5) @(negedge clk);
    checks++; if (op_count !== 4'd2) $display("FAIL bp_count2: got %0d want 2", op_count); else passes++;
  endtask

  task automatic test_illegal();
    int ok;
    do_reset();
    @(posedge clk); #1;
    bus.req_op[11:9] = 3'd7;
    bus.req_a[31:24] = 8'hAA;
    bus.req_b[31:24] = 8'h55;
    bus.req_valid = 4'b1000;
    wait_grant(ok);
    @(posedge clk); #1 bus.req_valid = 4'h0;
    wait_res(ok);
    checks++; if (bus.res_data !== 8'h00) $display("FAIL ill_data: got %h want 00", bus.res_data); else passes++;
    checks++; if (bus.res_err !== 1'b1) $display("FAIL ill_err: got %b want 1", bus.res_err); else passes++;
    checks++; if (bus.res_id !== 2'd3) $display("FAIL ill_id: got %0d want 3", bus.res_id); else passes++;
    checks++; if (op_count !== 4'd0) $display("FAIL ill_pre: got %0d want 0", op_count); else passes++;
    @(negedge clk);
    checks++; if (op_count !== 4'd1) $display("FAIL ill_opcnt: got %0d want 1", op_count); else passes++;
    checks++; if (err_count !== 4'd1) $display("FAIL ill_errcnt: got %0d want 1", err_count); else passes++;
  endtask

  task automatic test_async_reset();
    int ok;
    do_reset();
    @(posedge clk); #1;
    bus.req_op = {3'd1, 3'd0, 3'd6, 3'd5};
    bus.req_a = {8'h81, 8'h42, 8'h24, 8'h18};
    bus.req_b = {8'h0F, 8'h3C, 8'hC3, 8'hF0};
    bus.req_valid = 4'b1000;
    wait_grant(ok);
    @(posedge clk); #1 bus.req_valid = 4'h0;
    wait_res(ok);
    @(negedge clk);
    checks++; if (op_count !== 4'd1) $display("FAIL ar_pre: got %0d want 1", op_count); else passes++;
    @(posedge clk); #1 bus.req_valid = 4'b0110;
    wait_grant(ok);
    @(posedge clk); #2 rst = 1'b1;
    #1;
    checks++; if (bus.res_valid !== 1'b0) $display("FAIL ar_valid: got %b want 0", bus.res_valid); else passes++;
    checks++; if (bus.res_id !== 2'd0) $display("FAIL ar_id: got %0d want 0", bus.res_id); else passes++;
    checks++; if (bus.res_data !== 8'h00) $display("FAIL ar_data: got %h want 00", bus.res_data); else passes++;
    checks++; if (bus.req_ready !== 4'h0) $display("FAIL ar_ready: got %b want 0000", bus.req_ready); else passes++;
    checks++; if (op_count !== 4'd0) $display("FAIL ar_count: got %0d want 0", op_count); else passes++;
    sb.delete();
    @(posedge clk); #1 rst = 1'b0;
    wait_grant(ok);
    checks++; if (bus.req_ready !== 4'b0010) $display("FAIL ar_first: got %b want 0010", bus.req_ready); else passes++;
    @(posedge clk); #1 bus.req_valid = 4'b0100;
    wait_grant(ok);
    checks++; if (bus.req_ready !== 4'b0100) $display("FAIL ar_second: got %b want 0100", bus.req_ready); else passes++;
    @(posedge clk); #1 bus.req_valid = 4'h0;
    repeat (5) @(negedge clk);
    checks++; if (op_count !== 4'd2) $display("FAIL ar_post: got %0d want 2", op_count); else passes++;
  endtask

  task automatic test_saturation();
    int ok;
    logic [3:0] mop;
    logic [3:0] merr;
    do_reset();
    mop = 4'd0;
    merr = 4'd0;
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #1;
      bus.req_op[2:0] = (i < 2) ? 3'd5 : 3'd7;
      bus.req_a[7:0] = 8'(i);
      bus.req_b[7:0] = 8'h0F;
      bus.req_valid = 4'b0001;
      wait_grant(ok);
      @(posedge clk); #1 bus.req_valid = 4'h0;
      wait_res(ok);
      @(negedge clk);
      if (mop != 4'd15) mop = mop + 4'd1;
      if (i >= 2 && merr != 4'd15) merr = merr + 4'd1;
      checks++; if (op_count !== mop) $display("FAIL sat_op%0d: got %0d want %0d", i, op_count, mop); else passes++;
      checks++; if (err_count !== merr) $display("FAIL sat_err%0d: got %0d want %0d", i, err_count, merr); else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_ops();
    test_round_robin();
    test_backpressure();
    test_illegal();
    test_async_reset();
    test_saturation();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
